// File: rtl/name_seq_detector.sv
// Receive-side detector for the 17-character sequence "Alexandr Nosenko ", with a one-hot position output.
// Optional build macro NAME_CASE_FOLD_EN enables case-insensitive letter comparison.
module name_seq_detector #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             VALID,
    input  logic [0:7]       DIN,
    output logic [0:16]      Q,
    output logic             MATCH,
    output logic             ERR,
    output logic [CNT_W-1:0] MCOUNT
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    function automatic logic [7:0] f_table(input logic [4:0] pos);
        case (pos)
            5'd0:    return 8'h41;
            5'd1:    return 8'h6C;
            5'd2:    return 8'h65;
            5'd3:    return 8'h78;
            5'd4:    return 8'h61;
            5'd5:    return 8'h6E;
            5'd6:    return 8'h64;
            5'd7:    return 8'h72;
            5'd9:    return 8'h4E;
            5'd10:   return 8'h6F;
            5'd11:   return 8'h73;
            5'd12:   return 8'h65;
            5'd13:   return 8'h6E;
            5'd14:   return 8'h6B;
            5'd15:   return 8'h6F;
            default: return 8'h20;
        endcase
    endfunction

    function automatic logic [7:0] f_fold(input logic [7:0] b);
`ifdef NAME_CASE_FOLD_EN
        if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))
            return b & 8'hDF;
        else
            return b;
`else
        return b;
`endif
    endfunction

    function automatic logic [0:16] f_onehot(input logic [4:0] pos);
        return 17'h1_0000 >> pos;
    endfunction

    state_t             r_state;
    logic [4:0]         r_pos;
    logic [0:16]        r_q;
    logic               r_match;
    logic               r_err;
    logic [CNT_W-1:0]   r_mcount;
    logic [TMO_W-1:0]   r_tmo;

    state_t             w_state_nxt;
    logic [4:0]         w_pos_nxt;
    logic [0:16]        w_q_nxt;
    logic               w_match_nxt;
    logic               w_err_nxt;
    logic [CNT_W-1:0]   w_mcount_nxt;
    logic [TMO_W-1:0]   w_tmo_nxt;

    logic [7:0]         w_din;
    logic [4:0]         w_next_pos;
    logic               w_cont;
    logic               w_is_a;
    logic               w_tmo_hit;

    // DIN[0] is the MSB, so a straight assignment lands it on w_din[7]
    assign w_din      = DIN;
    assign w_next_pos = (r_pos == 5'd16) ? 5'd0 : r_pos + 5'd1;
    assign w_cont     = (f_fold(w_din) == f_fold(f_table(w_next_pos)));
    assign w_is_a     = (f_fold(w_din) == 8'h41);
    assign w_tmo_hit  = (TIMEOUT != 0) && (r_tmo == TMO_W'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_pos_nxt    = r_pos;
        w_q_nxt      = r_q;
        w_match_nxt  = 1'b0;
        w_err_nxt    = 1'b0;
        w_mcount_nxt = r_mcount;
        w_tmo_nxt    = r_tmo;

        case (r_state)
            ST_IDLE: begin
                w_tmo_nxt = '0;
                if (VALID) begin
                    if (w_is_a) begin
                        w_state_nxt = ST_TRACK;
                        w_pos_nxt   = 5'd0;
                        w_q_nxt     = f_onehot(5'd0);
                    end else begin
                        w_q_nxt     = '0;
                    end
                end
            end
            ST_TRACK: begin
                if (VALID) begin
                    w_tmo_nxt = '0;
                    // Continuation is tested first so a folded 'a' at position 4 is not a restart
                    if (w_cont) begin
                        w_pos_nxt = w_next_pos;
                        w_q_nxt   = f_onehot(w_next_pos);
                        if (w_next_pos == 5'd16) begin
                            w_match_nxt = 1'b1;
                            if (r_mcount != '1)
                                w_mcount_nxt = r_mcount + 1'b1;
                        end
                    end else if (r_pos == 5'd16) begin
                        w_state_nxt = ST_IDLE;
                        w_q_nxt     = '0;
                    end else begin
                        w_err_nxt = 1'b1;
                        if (w_is_a) begin
                            w_pos_nxt = 5'd0;
                            w_q_nxt   = f_onehot(5'd0);
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_q_nxt     = '0;
                        end
                    end
                end else if (TIMEOUT != 0 && r_pos != 5'd16) begin
                    if (w_tmo_hit) begin
                        w_state_nxt = ST_IDLE;
                        w_q_nxt     = '0;
                        w_err_nxt   = 1'b1;
                        w_tmo_nxt   = '0;
                    end else begin
                        w_tmo_nxt = r_tmo + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_q_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_IDLE;
            r_pos    <= '0;
            r_q      <= '0;
            r_match  <= 1'b0;
            r_err    <= 1'b0;
            r_mcount <= '0;
            r_tmo    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pos    <= w_pos_nxt;
            r_q      <= w_q_nxt;
            r_match  <= w_match_nxt;
            r_err    <= w_err_nxt;
            r_mcount <= w_mcount_nxt;
            r_tmo    <= w_tmo_nxt;
        end
    end

    assign Q      = r_q;
    assign MATCH  = r_match;
    assign ERR    = r_err;
    assign MCOUNT = r_mcount;

endmodule

// File: tb/tb_name_seq_detector.sv
// Directed self-checking bench for name_seq_detector with hand-computed expectations.
module tb_name_seq_detector;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 15;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             VALID;
    logic [0:7]       DIN;
    logic [0:16]      Q;
    logic             MATCH;
    logic             ERR;
    logic [CNT_W-1:0] MCOUNT;

    int    n_checks = 0;
    int    n_fail   = 0;
    string NAME     = "Alexandr Nosenko ";
    string FOLDED   = "aLEXANDR nOSENKO ";

    always #5 CLK = ~CLK;

    name_seq_detector #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .VALID  (VALID),
        .DIN    (DIN),
        .Q      (Q),
        .MATCH  (MATCH),
        .ERR    (ERR),
        .MCOUNT (MCOUNT)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Q[0] is the leftmost bit, so position p reads numerically as 1 << (16 - p)
    function automatic logic [31:0] qv(input int p);
        if (p < 0) return 32'h0;
        return 32'h1_0000 >> p;
    endfunction

    task automatic send(input byte b);
        VALID = 1'b1;
        DIN   = b;
        @(posedge CLK);
        #1;
        VALID = 1'b0;
        DIN   = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset;
        RST_N = 1'b0;
        VALID = 1'b0;
        DIN   = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        do_reset;
        check_eq("rst_q",      32'(Q),      qv(-1));
        check_eq("rst_match",  32'(MATCH),  0);
        check_eq("rst_err",    32'(ERR),    0);
        check_eq("rst_mcount", 32'(MCOUNT), 0);

        // Two full names back to back: Q walks 0..16 twice, 16 -> 0 on the second 'A'
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 17; i++) begin
                send(NAME[i]);
                check_eq("walk_q",     32'(Q),     qv(i));
                check_eq("walk_match", 32'(MATCH), (i == 16) ? 32'd1 : 32'd0);
                check_eq("walk_err",   32'(ERR),   0);
            end
            check_eq("walk_mcount", 32'(MCOUNT), 32'(r + 1));
        end

        // Position 16 holds indefinitely and leaves silently on a non-'A'
        idle(20);
        check_eq("hold16_q",     32'(Q),     qv(16));
        check_eq("hold16_err",   32'(ERR),   0);
        check_eq("hold16_match", 32'(MATCH), 0);
        send("x");
        check_eq("wrap_x_q",   32'(Q),   qv(-1));
        check_eq("wrap_x_err", 32'(ERR), 0);

        // Overlap restart: "Ale" + 'A' + "lexandr Nosenko "
        do_reset;
        send("A"); send("l"); send("e");
        check_eq("ovl_pre_q", 32'(Q), qv(2));
        send("A");
        check_eq("ovl_err", 32'(ERR), 1);
        check_eq("ovl_q",   32'(Q),   qv(0));
        for (int i = 1; i < 17; i++) begin
            send(NAME[i]);
            check_eq("ovl_walk_q", 32'(Q), qv(i));
        end
        check_eq("ovl_match",  32'(MATCH),  1);
        check_eq("ovl_err_end", 32'(ERR),   0);
        check_eq("ovl_mcount", 32'(MCOUNT), 1);

        // Mismatch to IDLE, then a stray 'l' is ignored
        do_reset;
        send("A"); send("l"); send("e"); send("x");
        send("Z");
        check_eq("mis_err", 32'(ERR), 1);
        check_eq("mis_q",   32'(Q),   qv(-1));
        send("l");
        check_eq("mis_l_q",   32'(Q),   qv(-1));
        check_eq("mis_l_err", 32'(ERR), 0);

        // Timeout: 15 idle cycles abort, 14 do not
        do_reset;
        send("A"); send("l");
        for (int i = 0; i < 14; i++) begin
            idle(1);
            check_eq("tmo_wait_err", 32'(ERR), 0);
        end
        check_eq("tmo_hold_q", 32'(Q), qv(1));
        idle(1);
        check_eq("tmo_err", 32'(ERR), 1);
        check_eq("tmo_q",   32'(Q),   qv(-1));
        idle(1);
        check_eq("tmo_err_pulse", 32'(ERR), 0);
        send("A"); send("l");
        idle(14);
        send("e");
        check_eq("tmo14_err", 32'(ERR), 0);
        check_eq("tmo14_q",   32'(Q),   qv(2));

        // Asynchronous reset mid-sequence
        do_reset;
        for (int i = 0; i < 17; i++) send(NAME[i]);
        for (int i = 0; i < 10; i++) send(NAME[i]);
        check_eq("arst_pre_q",      32'(Q),      qv(9));
        check_eq("arst_pre_mcount", 32'(MCOUNT), 1);
        #1;
        RST_N = 1'b0;
        #1;
        check_eq("arst_q",      32'(Q),      qv(-1));
        check_eq("arst_mcount", 32'(MCOUNT), 0);
        RST_N = 1'b1;
        send("l");
        check_eq("arst_after_q", 32'(Q), qv(-1));

        // MCOUNT saturation at 255
        do_reset;
        for (int r = 0; r < 256; r++)
            for (int i = 0; i < 17; i++) send(NAME[i]);
        check_eq("sat_mcount", 32'(MCOUNT), 255);
        check_eq("sat_match",  32'(MATCH),  1);

`ifdef NAME_CASE_FOLD_EN
        do_reset;
        for (int i = 0; i < 17; i++) begin
            send(FOLDED[i]);
            check_eq("fold_q", 32'(Q), qv(i));
        end
        check_eq("fold_match",  32'(MATCH),  1);
        check_eq("fold_mcount", 32'(MCOUNT), 1);
        do_reset;
        send("A"); send("l"); send("e"); send("x"); send("A");
        check_eq("fold_cont_q",   32'(Q),   qv(4));
        check_eq("fold_cont_err", 32'(ERR), 0);
`else
        do_reset;
        send(FOLDED[0]);
        check_eq("exact_a_q",   32'(Q),   qv(-1));
        check_eq("exact_a_err", 32'(ERR), 0);
        send("A"); send("l"); send("e"); send("x"); send("A");
        check_eq("exact_rst_q",   32'(Q),   qv(0));
        check_eq("exact_rst_err", 32'(ERR), 1);
        send("L");
        check_eq("exact_L_q",   32'(Q),   qv(-1));
        check_eq("exact_L_err", 32'(ERR), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/name_seq_detector.md
Name: name_seq_detector

Overview:
- Receive-side counterpart of the one-hot ring sequencer plus character coder pair.
- Accepts a stream of 8-bit ASCII bytes and tracks them against the fixed 17-character name sequence "Alexandr Nosenko " (position 0..16).
- Reports the matched position as a 17-bit one-hot vector, in the same format the ring counter drives.
- Pulses on complete-sequence match and on mismatch, and counts completed matches.

Parameters:
- CNT_W, 8: width of the match counter MCOUNT; saturates at 2^CNT_W-1.
- TIMEOUT, 15: idle cycles allowed between accepted bytes mid-sequence before abort. 0 disables the timeout.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- VALID  input  1  DIN is sampled on every rising edge where VALID=1.
- DIN  input  [0:7]  ASCII byte; DIN[0] is MSB (same bit order as the coder's C).
- Q  output  [0:16]  one-hot index of the last matched position; all-zero when not tracking.
- MATCH  output  1  one-cycle pulse: position 16 accepted, so the full sequence was received.
- ERR  output  1  one-cycle pulse: mismatch or timeout while tracking.
- MCOUNT  output  [CNT_W-1:0]  number of completed matches, saturating.

Behaviour:
- Expected table, positions 0..16, hex: 41 6C 65 78 61 6E 64 72 20 4E 6F 73 65 6E 6B 6F 20 ("Alexandr Nosenko ").
- Reset, asynchronous on RST_N=0:
  - Q=0, MATCH=0, ERR=0, MCOUNT=0, timeout counter=0, state=IDLE.
  - Reset mid-sequence discards all progress immediately.
- States:
  - IDLE: expect position 0.
  - TRACK(k), k=0..16: last matched position is k, so the next expected position is (k+1) mod 17.
- Outputs are registered. Latency is 1 cycle from the sampling edge to Q, MATCH and ERR.
- IDLE with VALID=1:
  - DIN=0x41: go to TRACK(0), Q=one-hot bit 0.
  - Any other byte: stay in IDLE, Q=0, no ERR.
- TRACK(k) with VALID=1 and DIN=table[(k+1) mod 17]: go to TRACK((k+1) mod 17), Q shifts one position toward bit 16.
- Entry into TRACK(16):
  - MATCH=1 for that cycle.
  - MCOUNT increments, holding at maximum.
  - Q[16]=1.
- TRACK(16), wrap:
  - Next expected byte is 0x41; on it, go to TRACK(0).
  - Any other byte: go to IDLE silently, no ERR. The sequence already completed.
- TRACK(k), k<16, mismatch:
  - ERR=1 for that cycle.
  - If DIN=0x41: restart to TRACK(0), Q=bit 0. 'A' occurs only at position 0, so this is exact overlap handling.
  - Else: go to IDLE, Q=0.
- VALID=0: state and Q hold. MATCH and ERR are pulses and return to 0.
- Timeout, only when TIMEOUT>0:
  - The counter runs only in TRACK(k) with k<16 and VALID=0, and clears on any accepted byte.
  - When it reaches TIMEOUT: go to IDLE, Q=0, ERR=1 for one cycle.
  - TRACK(16) never times out; it holds until the next byte.
- Simultaneous timeout expiry and VALID=1 in the same cycle: the byte wins and the counter clears.
- Q is always either all-zero or exactly one-hot.
- MATCH and ERR are never both 1 in the same cycle.

Optional Feature:
- Macro NAME_CASE_FOLD_EN.
- Defined: DIN and table letters are compared case-insensitively. Bytes 0x41-0x5A and 0x61-0x7A fold by clearing bit 0x20; non-letters compare exactly. Continuation takes priority over restart, so 0x41 at expected position 4 ('a') continues to TRACK(4). 0x61 in IDLE starts TRACK(0).
- Not defined: exact 8-bit compare as described above.

Test Plan:
- Reset then the 17 bytes "Alexandr Nosenko " on consecutive cycles -> Q walks bit 0..16 one per cycle; MATCH=1 exactly on the 17th; MCOUNT=1; ERR never set.
- Same stream twice back-to-back (34 bytes) -> two MATCH pulses 17 cycles apart, MCOUNT=2; Q goes bit 16 -> bit 0 on the second 'A'.
- "Ale" then 0x41 then "lexandr Nosenko " -> ERR on the 0x41 cycle with Q=bit 0; MATCH at the end; MCOUNT=1.
- "Alex" then 0x5A ('Z') -> ERR=1, Q=0, state IDLE; a following 'l' causes no response.
- TIMEOUT=15: "Al" then VALID=0 for 15 cycles -> ERR pulses on the 15th idle cycle, Q=0. With 14 idle cycles followed by 'e' -> no ERR, Q=bit 2.
- RST_N pulsed low mid-sequence at Q=bit 9 -> Q=0 and MCOUNT=0 immediately. With NAME_CASE_FOLD_EN: "aLEXANDR nOSENKO " -> MATCH, MCOUNT=1.
